serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001: Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002: clk  input  1  single clock; all state changes on rising edge.
REQ-003: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004: in_valid  input  1  operand pair (a, b, cin) offered.
REQ-005: in_ready  output  1  block can accept an operand pair.
REQ-006: a  input  WIDTH  first operand, unsigned.
REQ-007: b  input  WIDTH  second operand, unsigned.
REQ-008: cin  input  1  carry-in for bit 0.
REQ-009: out_valid  output  1  result available.
REQ-010: out_ready  input  1  consumer accepts the result.
REQ-011: sum  output  WIDTH  a + b + cin, low WIDTH bits.
REQ-012: cout  output  1  carry out of bit WIDTH-1.
REQ-013: busy  output  1  high in RUN or DONE.

Function
REQ-014: The datapath SHALL be one bit-serial full adder built from two half-adder stages plus an OR gate; no WIDTH-bit parallel adder.
REQ-015: The FSM SHALL have states IDLE, RUN and DONE.
REQ-016: in_ready SHALL equal (state == IDLE); out_valid SHALL equal (state == DONE).
REQ-017: In IDLE, in_valid && in_ready SHALL capture a and b into shift registers, cin into the carry register and 0 into the bit counter, and move to RUN.
REQ-018: Each RUN cycle SHALL add operand bit [cnt] with the carry register, shift the sum bit into the sum register at position cnt, update carry and increment cnt.
REQ-019: When cnt == WIDTH-1 in RUN, the FSM SHALL process that bit and move to DONE, giving out_valid exactly WIDTH cycles after the accept edge.
REQ-020: In DONE, sum and cout SHALL hold stable until out_valid && out_ready; that edge SHALL return the FSM to IDLE.
REQ-021: in_valid SHALL be ignored in RUN and DONE; a new operand pair SHALL NOT be accepted on the edge that completes the output handshake.
REQ-022: Changes on a, b or cin after capture SHALL NOT affect the result in progress.
REQ-023: sum and cout SHALL be exact: {cout, sum} == a + b + cin for all inputs, including wrap-around at 2^WIDTH.

Reset
REQ-024: rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, counter=0 and carry=0.
REQ-025: A reset in RUN or DONE SHALL discard the operation; no out_valid pulse SHALL follow reset release.
REQ-026: After reset release, the block SHALL accept an operand pair on the first rising edge with in_valid high.

Configuration
REQ-027: Macro SERIAL_ADDER_OVF_EN defined SHALL add output port ovf (1 bit): the two's-complement overflow flag, carry into bit WIDTH-1 XOR cout, valid with out_valid, reset to 0.
REQ-028: Without SERIAL_ADDER_OVF_EN, ovf SHALL be absent and no logic SHALL be generated for it; all other behaviour SHALL be identical.

Verification (WIDTH=8, SERIAL_ADDER_OVF_EN defined unless noted)
REQ-029: a=0x00, b=0x00, cin=0 -> out_valid 8 cycles after accept, sum=0x00, cout=0, ovf=0.
REQ-030: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
REQ-031: a=0xA5, b=0x5A, cin=1, out_ready held low 5 cycles after out_valid -> sum=0x00, cout=1, values stable, in_ready=0 throughout, IDLE one edge after out_ready rises.
REQ-032: Accept a=0x12, b=0x34; drive in_valid with a=0xFF during RUN -> sum=0x46, cout=0, second pair never accepted while busy.
REQ-033: rst_n pulsed low 3 cycles into RUN -> outputs zero at once, no out_valid after release; next pair a=0x03, b=0x04 -> sum=0x07.
REQ-034: Macro undefined build: repeat REQ-029 and REQ-030 -> identical sum/cout/timing, no ovf port.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
// Optional macro SERIAL_ADDER_OVF_EN adds the ovf result flag.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder with valid/ready handshakes: one full-adder bit per cycle, LSB first.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow flag.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_ctrl_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Full adder as two half adders; the carries can never both be set, so OR merges them.
    logic ha0_s, ha0_c, ha1_s, ha1_c, fa_co;
    assign ha0_s = a_q[0] ^ b_q[0];
    assign ha0_c = a_q[0] & b_q[0];
    assign ha1_s = ha0_s ^ carry_q;
    assign ha1_c = ha0_s & carry_q;
    assign fa_co = ha0_c | ha1_c;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Operands shift down so bit cnt is always at position 0; sum bits enter
                // at the top and land at position cnt after the final shift.
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {ha1_s, sum_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_q ^ fa_co;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: arithmetic/timing model checked every cycle plus literal vectors.
// Builds with or without SERIAL_ADDER_OVF_EN.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();
    serial_adder_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted pair's result is due W edges after the accept edge and
    // stays pending until an edge sees out_ready; no accept on that same edge.
    bit             m_active = 1'b0;
    int             cyc      = 0;
    int             m_acc    = 0;
    logic [W-1:0]   m_sum    = '0;
    logic           m_cout   = 1'b0;
    logic           m_ovf    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
        end else begin
            if (m_active && (cyc - m_acc >= W) && bus.out_ready) begin
                m_active = 1'b0;
            end else if (!m_active && bus.in_valid) begin
                logic [W:0] total;
                int sa, sb, ss;
                total  = bus.a + bus.b + bus.cin;
                sa     = $signed(bus.a);
                sb     = $signed(bus.b);
                ss     = sa + sb + (bus.cin ? 1 : 0);
                m_sum  = total[W-1:0];
                m_cout = total[W];
                m_ovf  = (ss > (2 ** (W - 1)) - 1) || (ss < -(2 ** (W - 1)));
                m_active = 1'b1;
                m_acc    = cyc + 1;
            end
            cyc = cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_sum", 32'(bus.sum), 32'd0);
            chk("rst_cout", 32'(bus.cout), 32'd0);
        end else begin
            logic exp_ov;
            exp_ov = m_active && (cyc - m_acc >= W);
            chk("mdl_in_ready", 32'(bus.in_ready), 32'(!m_active));
            chk("mdl_out_valid", 32'(bus.out_valid), 32'(exp_ov));
            chk("mdl_busy", 32'(bus.busy), 32'(m_active));
            if (exp_ov) begin
                chk("mdl_sum", 32'(bus.sum), 32'(m_sum));
                chk("mdl_cout", 32'(bus.cout), 32'(m_cout));
`ifdef SERIAL_ADDER_OVF_EN
                chk("mdl_ovf", 32'(bus.ovf), 32'(m_ovf));
`endif
            end
        end
    end

    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                          input logic tc, input bit junk, input int hold,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int lat;
        @(negedge clk); #1;
        bus.a = ta; bus.b = tbv; bus.cin = tc;
        bus.in_valid = 1'b1;
        bus.out_ready = (hold == 0);
        chk({name, "_ready_at_accept"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        // Disturb inputs after capture; optionally keep offering a new pair.
        bus.a = 8'hFF; bus.b = ~tbv; bus.cin = ~tc;
        bus.in_valid = junk;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(W));
        chk({name, "_sum"}, 32'(bus.sum), 32'(es));
        chk({name, "_cout"}, 32'(bus.cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        chk({name, "_ovf"}, 32'(bus.ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("unexpected x on ovf expectation");
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({name, "_hold_sum"}, 32'(bus.sum), 32'(es));
            chk({name, "_hold_cout"}, 32'(bus.cout), 32'(ec));
            chk({name, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk({name, "_idle_after_hs"}, 32'(bus.in_ready), 32'd1);
        chk({name, "_busy_after_hs"}, 32'(bus.busy), 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        $display("op %s: a=%0h b=%0h cin=%0d -> sum=%0h cout=%0d lat=%0d", name, ta, tbv, tc, es, ec, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov_seen;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        run_op("zero",   8'h00, 8'h00, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0);
        run_op("wrap",   8'hFF, 8'h01, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0);
        run_op("sovf",   8'h7F, 8'h01, 1'b0, 1'b0, 0, 8'h80, 1'b0, 1'b1);
        run_op("hold",   8'hA5, 8'h5A, 1'b1, 1'b1, 5, 8'h00, 1'b1, 1'b0);
        run_op("ignore", 8'h12, 8'h34, 1'b0, 1'b1, 0, 8'h46, 1'b0, 1'b0);
        run_op("negovf", 8'h80, 8'hFF, 1'b0, 1'b0, 2, 8'h7F, 1'b1, 1'b1);

        // Reset three cycles into RUN discards the operation.
        @(negedge clk); #1;
        bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_sum", 32'(bus.sum), 32'd0);
        chk("async_rst_cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("async_rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        @(negedge clk); #1 rst_n = 1'b1;
        ov_seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.out_valid) ov_seen++;
        end
        chk("no_valid_after_reset", 32'(ov_seen), 32'd0);
        $display("op reset_in_run: out_valid pulses after release=%0d", ov_seen);

        run_op("post_rst", 8'h03, 8'h04, 1'b0, 1'b0, 0, 8'h07, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
